// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with integrated controller.
// Operands X then Y arrive over the shared N-bit input bus. The 2N-bit
// product leaves over outBus as the high half, then the low half.
// Both operands are extended to N+1 bits, so signed and unsigned modes
// share the same Booth datapath and the same N+1 iteration count.
module booth_mult_seq #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         uns,
    input  logic [N-1:0] inBus,
    output logic         busy,
    output logic         outValid,
    output logic         outHi,
    output logic         done,
    output logic [N-1:0] outBus
);

    // Internal operand width; one extra bit lets unsigned operands look signed.
    localparam int W  = N + 1;
    // Counter must hold the value N+1.
    localparam int CW = $clog2(N + 2);

    typedef enum logic [2:0] {
        IDLE,
        LDY,
        CALC,
        OUTH,
        OUTL
    } state_t;

    state_t         state;
    state_t         nextState;

    logic [N-1:0]   xReg;
    logic           modeUns;
    logic [W:0]     acc;       // W+1 bits, so acc +/- X cannot overflow
    logic [W-1:0]   yReg;
    logic           yPrev;
    logic [CW-1:0]  count;

    logic [W-1:0]   xExt;
    logic [W:0]     xAcc;
    logic [W-1:0]   yLoad;
    logic [W:0]     sum;

    // Operand extension (zero for unsigned, sign for signed) and the Booth add/sub step.
    always_comb begin
        xExt  = {~modeUns & xReg[N-1], xReg};
        xAcc  = {xExt[W-1], xExt};
        yLoad = {~modeUns & inBus[N-1], inBus};
        case ({yReg[0], yPrev})
            2'b01:   sum = acc + xAcc;
            2'b10:   sum = acc - xAcc;
            default: sum = acc;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; start is looked at only in IDLE.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = LDY;
            LDY:     nextState = CALC;
            CALC:    if (count == CW'(1)) nextState = OUTH;
            OUTH:    nextState = OUTL;
            OUTL:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are decoded from state and registers only, never from inputs.
    always_comb begin
        busy     = (state != IDLE);
        outValid = (state == OUTH) || (state == OUTL);
        outHi    = (state == OUTH);
        done     = (state == OUTL);
        outBus   = '0;
        case (state)
            OUTH:    outBus = {acc[N-2:0], yReg[N]};   // product[2N-1:N]
            OUTL:    outBus = yReg[N-1:0];             // product[N-1:0]
            default: outBus = '0;
        endcase
    end

    // Datapath: capture X/mode, load Y, then one Booth iteration per CALC cycle.
    // acc and yReg are left untouched outside LDY/CALC, so the product holds in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xReg    <= '0;
            modeUns <= 1'b0;
            acc     <= '0;
            yReg    <= '0;
            yPrev   <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xReg    <= inBus;
                        modeUns <= uns;
                    end
                end
                LDY: begin
                    yReg  <= yLoad;
                    acc   <= '0;
                    yPrev <= 1'b0;
                    count <= CW'(N + 1);
                end
                CALC: begin
                    // Arithmetic right shift of {acc, yReg, yPrev} after the add.
                    acc   <= {sum[W], sum[W:1]};
                    yReg  <= {sum[0], yReg[W-1:1]};
                    yPrev <= yReg[0];
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: one N=6 and one N=8 instance share clk/rst.
// A per-instance model (product by plain integer multiply, timing by cycles
// since the start edge) is compared against the outputs on every falling
// edge; directed operations add hand-computed literal expectations.
module tb_booth_mult_seq;

    logic       clk;
    logic       rst;
    logic [1:0] startIn;
    logic [1:0] unsIn;
    logic [5:0] bus6;
    logic [7:0] bus8;
    logic [1:0] busyO;
    logic [1:0] validO;
    logic [1:0] hiO;
    logic [1:0] doneO;
    logic [5:0] out6;
    logic [7:0] out8;

    int errors = 0;
    int checks = 0;
    bit armed  = 0;

    booth_mult_seq #(.N(6)) u6 (
        .clk(clk), .rst(rst), .start(startIn[0]), .uns(unsIn[0]), .inBus(bus6),
        .busy(busyO[0]), .outValid(validO[0]), .outHi(hiO[0]), .done(doneO[0]), .outBus(out6)
    );

    booth_mult_seq #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(startIn[1]), .uns(unsIn[1]), .inBus(bus8),
        .busy(busyO[1]), .outValid(validO[1]), .outHi(hiO[1]), .done(doneO[1]), .outBus(out8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widthOf(input int k);
        return (k == 0) ? 6 : 8;
    endfunction

    function automatic logic [7:0] busOf(input int k);
        return (k == 0) ? {2'b00, out6} : out8;
    endfunction

    // Reference product: interpret operands per mode, multiply, keep 2n bits.
    function automatic logic [15:0] refProd(input int n, input logic u,
                                            input logic [7:0] x, input logic [7:0] y);
        longint a, b, m;
        m = (longint'(1) << n) - 1;
        a = longint'(x) & m;
        b = longint'(y) & m;
        if (!u && a >= (longint'(1) << (n - 1))) a -= (longint'(1) << n);
        if (!u && b >= (longint'(1) << (n - 1))) b -= (longint'(1) << n);
        return 16'((a * b) & ((longint'(1) << (2 * n)) - 1));
    endfunction

    // Model: age = cycles since the accepted start edge (0 = idle).
    int          age   [2];
    logic [7:0]  mX    [2];
    logic        mUns  [2];
    logic [15:0] mProd [2];

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                age[k] <= 0;
            end else if (age[k] == 0) begin
                if (startIn[k]) begin
                    mX[k]   <= (k == 0) ? {2'b00, bus6} : bus8;
                    mUns[k] <= unsIn[k];
                    age[k]  <= 1;
                end
            end else if (age[k] == 1) begin
                mProd[k] <= refProd(widthOf(k), mUns[k], mX[k], (k == 0) ? {2'b00, bus6} : bus8);
                age[k]   <= 2;
            end else if (age[k] == widthOf(k) + 4) begin
                age[k] <= 0;
            end else begin
                age[k] <= age[k] + 1;
            end
        end
    end

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                int          n;
                logic [15:0] mask;
                logic [7:0]  expBus;
                n    = widthOf(k);
                mask = 16'((1 << n) - 1);
                expBus = 8'h00;
                if (age[k] == n + 3) expBus = 8'((mProd[k] >> n) & mask);
                if (age[k] == n + 4) expBus = 8'(mProd[k] & mask);
                check($sformatf("busy%0d", k),  32'(busyO[k]),  32'(age[k] != 0));
                check($sformatf("valid%0d", k), 32'(validO[k]), 32'(age[k] == n + 3 || age[k] == n + 4));
                check($sformatf("hi%0d", k),    32'(hiO[k]),    32'(age[k] == n + 3));
                check($sformatf("done%0d", k),  32'(doneO[k]),  32'(age[k] == n + 4));
                check($sformatf("bus%0d", k),   32'(busOf(k)),  32'(expBus));
            end
        end
    end

    task automatic drive(input int k, input logic s, input logic u, input logic [7:0] b);
        startIn[k] = s;
        unsIn[k]   = u;
        if (k == 0) bus6 = b[5:0];
        else        bus8 = b;
    endtask

    // One operation with literal expectations. launched: start/X already driven.
    // disturb: pulse start with other data during CALC. holdNext: raise start
    // with X=nx in OUTH and leave it high for the following operation.
    task automatic runOp(input string name, input int k, input logic u,
                         input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] expHi, input logic [7:0] expLo,
                         input bit launched, input bit disturb,
                         input bit holdNext, input logic nu, input logic [7:0] nx);
        int n;
        int cyc;
        bit found;
        n = widthOf(k);
        if (!launched) begin
            @(posedge clk); #1 drive(k, 1'b1, u, x);
        end
        @(posedge clk); #1 drive(k, 1'b0, 1'b0, y);        // E0 taken
        @(posedge clk); #1 drive(k, 1'b0, 1'b0, 8'h00);    // E1 taken
        cyc   = 1;
        found = 0;
        while (!found && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (disturb) drive(k, cyc == 3, 1'b1, (cyc == 3) ? 8'h11 : 8'h00);
            @(negedge clk);
            if (validO[k] && hiO[k]) found = 1;
        end
        check({name, " latency"}, 32'(cyc), 32'(n + 2));
        check({name, " hi"}, 32'(busOf(k)), 32'(expHi));
        check({name, " done-in-hi"}, 32'(doneO[k]), 32'd0);
        if (holdNext) drive(k, 1'b1, nu, nx);
        @(negedge clk);
        check({name, " lo-valid"}, 32'(validO[k] && !hiO[k]), 32'd1);
        check({name, " lo"}, 32'(busOf(k)), 32'(expLo));
        check({name, " done"}, 32'(doneO[k]), 32'd1);
        @(negedge clk);
        check({name, " idle"}, 32'(busyO[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        #8;
        check("reset busy",  32'(busyO),  32'd0);
        check("reset valid", 32'(validO), 32'd0);
        check("reset done",  32'(doneO),  32'd0);
        check("reset bus",   32'({out8, 2'b00, out6}), 32'd0);
        #4 rst = 1'b1;                       // t=12, away from any edge
        armed = 1;

        runOp("s -3*5",     0, 1'b0, 8'h3D, 8'h05, 8'h3F, 8'h31, 0, 0, 0, 1'b0, 8'h00);
        runOp("u 63*63",    0, 1'b1, 8'h3F, 8'h3F, 8'h3E, 8'h01, 0, 0, 0, 1'b0, 8'h00);
        runOp("s -1*-1",    0, 1'b0, 8'h3F, 8'h3F, 8'h00, 8'h01, 0, 0, 0, 1'b0, 8'h00);
        runOp("s -32*-32",  0, 1'b0, 8'h20, 8'h20, 8'h10, 8'h00, 0, 0, 0, 1'b0, 8'h00);
        runOp("s -32*31",   0, 1'b0, 8'h20, 8'h1F, 8'h30, 8'h20, 0, 0, 0, 1'b0, 8'h00);
        runOp("disturbed",  0, 1'b0, 8'h3D, 8'h05, 8'h3F, 8'h31, 0, 1, 0, 1'b0, 8'h00);
        runOp("chain a",    0, 1'b1, 8'h3F, 8'h3F, 8'h3E, 8'h01, 0, 0, 1, 1'b0, 8'h3D);
        runOp("chain b",    0, 1'b0, 8'h3D, 8'h3D, 8'h00, 8'h09, 1, 0, 0, 1'b0, 8'h00);

        // Reset in the middle of CALC aborts the operation.
        @(posedge clk); #1 drive(0, 1'b1, 1'b0, 8'h05);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h07);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #2 check("pre-reset busy", 32'(busyO[0]), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("abort busy",  32'(busyO[0]),  32'd0);
        check("abort valid", 32'(validO[0]), 32'd0);
        check("abort done",  32'(doneO[0]),  32'd0);
        check("abort bus",   32'(out6),      32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        runOp("post-reset 2*3", 0, 1'b0, 8'h02, 8'h03, 8'h00, 8'h06, 0, 0, 0, 1'b0, 8'h00);

        runOp("n8 u 200*3", 1, 1'b1, 8'hC8, 8'h03, 8'h02, 8'h58, 0, 0, 0, 1'b0, 8'h00);
        runOp("n8 s -5*7",  1, 1'b0, 8'hFB, 8'h07, 8'hFF, 8'hDD, 0, 0, 0, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
